ysyx_22050710_dmem_resp: RTL



---
 rtl/ysyx_22050710_dmem_resp_if.sv | 24 ++
 rtl/ysyx_22050710_dmem_resp.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_dmem_resp_if.sv
// Request/response bus between the load/store unit and the data-memory responder.
// Signal names are from the responder's point of view.
interface ysyx_22050710_dmem_resp_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wen;
  logic [63:0] i_req_addr;
  logic [63:0] i_req_wdata;
  logic [7:0]  i_req_wmask;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [63:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport master (
    output i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wmask, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wmask, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/ysyx_22050710_dmem_resp.sv
// Fixed-latency data-memory responder: one request in flight, byte-masked stores,
// lane-shifted loads, range error for addresses outside the array window.
module ysyx_22050710_dmem_resp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  ysyx_22050710_dmem_resp_if.slave      bus
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [60:0] BASE_W   = BASE[63:3];
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic        LAT_ONE  = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [63:0] r_rdata;
  logic        r_err;
  logic        r_wen;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wmask;
  logic [63:0] r_mem [0:DEPTH-1];

  logic                  w_accept;
  logic                  w_from_bus;
  logic                  w_acc_wen;
  logic [63:0]           w_acc_addr;
  logic [63:0]           w_acc_wdata;
  logic [7:0]            w_acc_wmask;
  logic [60:0]           w_word_off;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [5:0]            w_shamt;
  logic [7:0]            w_mask_sh;
  logic [63:0]           w_wdata_sh;
  logic                  w_enter_resp;
  logic                  w_mem_we;
  logic [63:0]           w_rdata_next;

  // With LATENCY==1 the array is accessed on the accept edge itself, so the
  // access operands come straight from the bus while still in IDLE.
  assign w_accept    = (r_state == S_IDLE) && bus.i_req_valid;
  assign w_from_bus  = (r_state == S_IDLE);
  assign w_acc_wen   = w_from_bus ? bus.i_req_wen   : r_wen;
  assign w_acc_addr  = w_from_bus ? bus.i_req_addr  : r_addr;
  assign w_acc_wdata = w_from_bus ? bus.i_req_wdata : r_wdata;
  assign w_acc_wmask = w_from_bus ? bus.i_req_wmask : r_wmask;

  assign w_word_off  = w_acc_addr[63:3] - BASE_W;
  assign w_in_range  = (w_acc_addr[63:3] >= BASE_W) &&
                       (w_word_off[60:DEPTH_LOG2] == {(61-DEPTH_LOG2){1'b0}});
  assign w_idx       = w_word_off[DEPTH_LOG2-1:0];
  assign w_shamt     = {w_acc_addr[2:0], 3'b000};
  // Left shifts truncate to the word, so lanes past byte 7 are simply dropped.
  assign w_mask_sh   = w_acc_wmask << w_acc_addr[2:0];
  assign w_wdata_sh  = w_acc_wdata << w_shamt;

  assign w_enter_resp = (r_state != S_RESP) && (w_state_next == S_RESP);
  assign w_mem_we     = w_enter_resp && w_acc_wen && w_in_range && i_rst_n;
  assign w_rdata_next = (w_in_range && !w_acc_wen) ? (r_mem[w_idx] >> w_shamt) : 64'd0;

  assign bus.o_req_ready = r_req_ready;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_rdata = r_rdata;
  assign bus.o_rsp_err   = r_err;

  // Next-state and latency counter decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.i_req_valid) begin
          w_cnt_next   = CNT_INIT;
          w_state_next = LAT_ONE ? S_RESP : S_WAIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.i_rsp_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_RESP;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // Control state, request latch and registered response outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 64'd0;
      r_err       <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= 64'd0;
      r_wdata     <= 64'd0;
      r_wmask     <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_req_ready <= (w_state_next == S_IDLE);
      r_rsp_valid <= (w_state_next == S_RESP);
      if (w_accept) begin
        r_wen   <= bus.i_req_wen;
        r_addr  <= bus.i_req_addr;
        r_wdata <= bus.i_req_wdata;
        r_wmask <= bus.i_req_wmask;
      end
      if (w_enter_resp) begin
        r_rdata <= w_rdata_next;
        r_err   <= !w_in_range;
      end
    end
  end

  // Storage array; deliberately not reset so contents survive a reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 8; b++) begin
      if (w_mem_we && w_mask_sh[b]) begin
        r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

endmodule
